// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one block every 52 cycles, round keys 9..0 are
// derived on the fly from the round-10 key through four time-shared S-boxes.
module aes128_inv_cipher_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] out_key,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_KEY  = 2'd1;
    localparam logic [1:0] S_COL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 without a special case).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(x, x);
        r = p;
        for (int i = 2; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic enc);
        logic [7:0] a;
        logic [7:0] y;
        if (enc) begin
            a = gf_inv(x);
            y = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
        end else begin
            a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
            y = gf_inv(a);
        end
        return y;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte at column c, row r; byte 0 sits in bits [127:120].
    function automatic logic [7:0] byte_of(input logic [127:0] s, input logic [1:0] c,
                                           input logic [1:0] r);
        return s[{4'd15 - {c, r}, 3'b000} +: 8];
    endfunction

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] nx_q, nx_d;
    logic [127:0] out_data_q, out_data_d;
    logic [127:0] out_key_q, out_key_d;
    logic         out_valid_q, out_valid_d;

    logic [31:0]  sb_in, sb_out;
    logic         sb_enc;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rk_col, col_val, col_mix;
    logic [127:0] col_mask, nx_ins;

    assign w3 = rk_q[31:0]   ^ rk_q[63:32];
    assign w2 = rk_q[63:32]  ^ rk_q[95:64];
    assign w1 = rk_q[95:64]  ^ rk_q[127:96];
    assign w0 = rk_q[127:96] ^ sb_out ^ {rcon(rnd_q + 4'd1), 24'h0};

    // S-box operands: RotWord(w3) during KEY, the InvShiftRows column during COL, else idle at zero.
    always_comb begin
        sb_enc = (state_q == S_KEY);
        sb_in  = '0;
        if (state_q == S_KEY) begin
            sb_in = {w3[23:0], w3[31:24]};
        end else if (state_q == S_COL) begin
            for (int r = 0; r < 4; r++) begin
                sb_in[8*(3-r) +: 8] = byte_of(st_q, col_q - 2'(r), 2'(r));
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sb_out[8*i +: 8] = sbox(sb_in[8*i +: 8], sb_enc);
    end

    assign rk_col   = rk_q[{2'd3 - col_q, 5'b00000} +: 32];
    assign col_val  = sb_out ^ rk_col;
    assign col_mix  = (rnd_q != 4'd0) ? inv_mix(col_val) : col_val;
    assign col_mask = {32'hffff_ffff, 96'h0} >> {col_q, 5'b00000};
    assign nx_ins   = (nx_q & ~col_mask) | ({col_mix, 96'h0} >> {col_q, 5'b00000});

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        rk_d        = rk_q;
        nx_d        = nx_q;
        out_data_d  = out_data_q;
        out_key_d   = out_key_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data ^ in_key;
                    rk_d    = in_key;
                    rnd_d   = 4'd9;
                    col_d   = 2'd0;
                    state_d = S_KEY;
                end
            end
            S_KEY: begin
                rk_d    = {w0, w1, w2, w3};
                col_d   = 2'd0;
                state_d = S_COL;
            end
            S_COL: begin
                nx_d = nx_ins;
                if (col_q == 2'd3) begin
                    st_d = nx_ins;
                    if (rnd_q == 4'd0) begin
                        out_valid_d = 1'b1;
                        out_data_d  = nx_ins;
                        out_key_d   = rk_q;
                        state_d     = S_DONE;
                    end else begin
                        rnd_d   = rnd_q - 4'd1;
                        state_d = S_KEY;
                    end
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            rnd_q       <= '0;
            st_q        <= '0;
            rk_q        <= '0;
            nx_q        <= '0;
            out_data_q  <= '0;
            out_key_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            nx_q        <= nx_d;
            out_data_q  <= out_data_d;
            out_key_q   <= out_key_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_key   = out_key_q;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Bench for aes128_inv_cipher_iter: FIPS vectors, backpressure, reset, back-to-back and
// random blocks produced by a forward-cipher model.
`timescale 1ns/1ps
module tb_aes128_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] out_key;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes128_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Forward S-box table: brute-force inverse search, then the affine map bit by bit.
    task automatic build_sbox();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = b;
        end
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] klast);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd != 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
        klast = {w[40], w[41], w[42], w[43]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers one block at the current falling edge and checks latency, result and handshake.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k10,
                             input logic [127:0] pt, input logic [127:0] k0);
        int cnt;
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = k10;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rand128();
        in_key   = ~k10;
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 128'(cnt), 128'd51);
        chk({tag, "_data"}, out_data, pt);
        chk({tag, "_key"}, out_key, k0);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_vld_drop"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [127:0] k, p, c, kl;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_key", out_key, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block("c1", C1_CT, C1_K10, C1_PT, C1_K0);
        run_block("fipsb", B_CT, B_K10, B_PT, B_K0);

        // Backpressure: result held while the consumer stalls, inputs ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        in_key    = C1_K10;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_latency", 128'(cnt), 128'd51);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
            in_key   = rand128();
            @(negedge clk);
            chk("bp_data", out_data, C1_PT);
            chk("bp_key", out_key, C1_K0);
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_busy", 128'(busy), 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_hold_data", out_data, C1_PT);
        chk("bp_hold_key", out_key, C1_K0);

        // Reset in the middle of a block.
        in_valid = 1'b1;
        in_data  = B_CT;
        in_key   = B_K10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_data", out_data, 128'd0);
        run_block("post_rst", C1_CT, C1_K10, C1_PT, C1_K0);

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        in_key    = C1_K10;
        @(negedge clk);
        in_data = B_CT;
        in_key  = B_K10;
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_first_latency", 128'(cnt), 128'd51);
        chk("b2b_first_data", out_data, C1_PT);
        chk("b2b_first_key", out_key, C1_K0);
        @(negedge clk);
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        chk("b2b_spacing", 128'(cnt), 128'd52);
        chk("b2b_second_data", out_data, B_PT);
        chk("b2b_second_key", out_key, B_K0);
        @(negedge clk);
        chk("b2b_idle", 128'(in_ready), 128'd1);

        for (int i = 0; i < 1000; i++) begin
            k = rand128();
            p = rand128();
            aes_enc(p, k, c, kl);
            run_block("rnd", c, kl, p, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
